passcode_entry: RTL

Front-end entry block for the combination lock: it conditions three raw push-buttons and a 4-bit digit switch bank, assembles a two-digit (8-bit) passcode attempt, and hands it to the lock core over a valid/ready handshake. It is the producing side of the lock's passcode-attempt interface and replaces direct switch wiring with debounced, single-event entry. It sits between board I/O and the lock core.

---
 rtl/combolock_pkg.sv | 7 +
 rtl/button_debouncer.sv | 41 ++++
 rtl/passcode_entry.sv | 109 ++++++++++
 3 files changed

// File: rtl/combolock_pkg.sv
// combolock_pkg: shared types and widths for the combination lock entry path.
// Provides entry_state_t (EMPTY, PARTIAL, FULL, SEND), PASSCODE_W and DIGIT_W.
package combolock_pkg;
    localparam int PASSCODE_W = 8;
    localparam int DIGIT_W    = 4;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, SEND} entry_state_t;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, debouncer and rising-edge event pulse.
// Ports: clk, rst_n (async active-low), raw (unsynchronized button),
//        pulse (one-cycle event when the debounced level goes 0->1).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    // The count only advances while the synchronized input disagrees with the
    // accepted level; any agreement restarts it. The pulse is issued in the
    // same edge that flips the level, so raw edge -> pulse is 2 + DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            pulse <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    pulse <= sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/passcode_entry.sv
// passcode_entry: debounced two-digit passcode entry feeding the lock core over valid/ready.
// Ports: clk, rst_n (async active-low), sw_digit[3:0], btn_push, btn_submit, btn_clear,
//        attempt_data[7:0], attempt_valid, attempt_ready, digit_count[1:0],
//        entry_error (short-entry submit pulse), entry_timeout (idle discard pulse).
// Build option: PASSCODE_ENTRY_TIMEOUT_EN enables the idle timeout; otherwise
//        entries persist and entry_timeout stays 0.
module passcode_entry
    import combolock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGIT_W-1:0]    sw_digit,
    input  logic                  btn_push,
    input  logic                  btn_submit,
    input  logic                  btn_clear,
    output logic [PASSCODE_W-1:0] attempt_data,
    output logic                  attempt_valid,
    input  logic                  attempt_ready,
    output logic [1:0]            digit_count,
    output logic                  entry_error,
    output logic                  entry_timeout
);
    logic                  push, submit, clear;
    logic [DIGIT_W-1:0]    sw_s1, sw_s2;
    entry_state_t          state, state_n;
    logic [PASSCODE_W-1:0] code, code_n;
    logic                  error_n, timeout_hit, timeout_n;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push (
        .clk(clk), .rst_n(rst_n), .raw(btn_push), .pulse(push));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit (
        .clk(clk), .rst_n(rst_n), .raw(btn_submit), .pulse(submit));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .rst_n(rst_n), .raw(btn_clear), .pulse(clear));

`ifdef PASSCODE_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle;
    assign timeout_hit = (state == PARTIAL || state == FULL) && idle == TW'(TIMEOUT_CYCLES - 1);
    // Every accepted event in PARTIAL/FULL changes state, so a state change
    // is the single restart condition; the count holds in EMPTY/SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle <= '0;
        else if (state_n != state)
            idle <= '0;
        else if (state == PARTIAL || state == FULL)
            idle <= idle + 1'b1;
    end
`else
    // Timeout disabled: the condition can never arise.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Priority clear > submit > push; SEND only waits for the transfer.
    always_comb begin
        state_n = state;
        code_n  = code;
        error_n = 1'b0;
        if (state == SEND) begin
            if (attempt_ready) begin
                state_n = EMPTY;
                code_n  = '0;
            end
        end else if (clear) begin
            state_n = EMPTY;
            code_n  = '0;
        end else if (submit) begin
            if (state == FULL)
                state_n = SEND;
            else
                error_n = 1'b1;
        end else if (push && state != FULL) begin
            state_n = (state == EMPTY) ? PARTIAL : FULL;
            code_n  = {code[DIGIT_W-1:0], sw_s2};
        end
        // A timeout only wins when no event moved the entry this cycle.
        timeout_n = timeout_hit && state_n == state;
        if (timeout_n) begin
            state_n = EMPTY;
            code_n  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            code          <= '0;
            sw_s1         <= '0;
            sw_s2         <= '0;
            entry_error   <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            code          <= code_n;
            sw_s1         <= sw_digit;
            sw_s2         <= sw_s1;
            entry_error   <= error_n;
            entry_timeout <= timeout_n;
        end
    end

    assign attempt_data  = code;
    assign attempt_valid = (state == SEND);
    assign digit_count   = (state == EMPTY) ? 2'd0 : (state == PARTIAL) ? 2'd1 : 2'd2;
endmodule
